// File: rtl/alu_cmd_ctrl_pkg.sv
// Shared types and constants for the ALU command controller.
package alu_cmd_ctrl_pkg;

  localparam int unsigned ALU_DW      = 8;
  localparam int unsigned ALU_OPW     = 4;
  localparam int unsigned ALU_NUM_OPS = 14;
  localparam int unsigned ALU_TIMEOUT = 16;

  typedef logic [ALU_OPW-1:0] opcode_t;

  typedef enum logic [3:0] {
    IDLE, GET_A, GET_B, GET_FUN, REQ, WAIT, SEND_LO, SEND_HI, SEND_ERR
  } ctrl_state_t;

  localparam logic [7:0] CMD_ALU_OP  = 8'hCC;
  localparam logic [7:0] CMD_ALU_NOP = 8'hDD;
  localparam logic [7:0] ERR_BAD_OP  = 8'hEE;
  localparam logic [7:0] ERR_TIMEOUT = 8'hFF;

  // Whole byte below num_ops means the upper bits are clear and the opcode is in range.
  function automatic logic is_valid_fun(input logic [7:0] b, input int unsigned num_ops);
    return 32'(b) < num_ops;
  endfunction

endpackage

// File: rtl/alu_cmd_ctrl.sv
// Assembles ALU commands from the UART RX byte stream, runs the ALU and returns
// the 16-bit result (LSB first) or a one-byte error code on the UART TX path.
module alu_cmd_ctrl
  import alu_cmd_ctrl_pkg::*;
#(
  parameter int unsigned DATA_WIDTH     = ALU_DW,
  parameter int unsigned OPCODE_WIDTH   = ALU_OPW,
  parameter int unsigned NUM_OPS        = ALU_NUM_OPS,
  parameter int unsigned TIMEOUT_CYCLES = ALU_TIMEOUT
) (
  input  logic                    CLK,
  input  logic                    RST,
  input  logic [7:0]              RX_P_DATA,
  input  logic                    RX_D_VLD,
  output logic                    ALU_EN,
  output logic [DATA_WIDTH-1:0]   ALU_A,
  output logic [DATA_WIDTH-1:0]   ALU_B,
  output opcode_t                 ALU_FUN,
  input  logic [2*DATA_WIDTH-1:0] ALU_OUT,
  input  logic                    ALU_OUT_VALID,
  output logic [7:0]              TX_P_DATA,
  output logic                    TX_D_VLD,
  input  logic                    TX_BUSY,
  output logic                    CTRL_BUSY
);

  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  if (DATA_WIDTH != 8) begin : g_dw_check
    $error("alu_cmd_ctrl: DATA_WIDTH must be 8");
  end
  if (OPCODE_WIDTH != ALU_OPW) begin : g_opw_check
    $error("alu_cmd_ctrl: OPCODE_WIDTH must match opcode_t");
  end
  if (NUM_OPS > (1 << OPCODE_WIDTH)) begin : g_ops_check
    $error("alu_cmd_ctrl: NUM_OPS exceeds the opcode space");
  end

  ctrl_state_t           state_q, state_d;
  logic [DATA_WIDTH-1:0] a_q, a_d, b_q, b_d, hi_q, hi_d;
  opcode_t               fun_q, fun_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic                  en_q, en_d;
  logic                  tx_vld_q, tx_vld_d;
  logic [7:0]            tx_data_q, tx_data_d;
  logic                  busy_q, busy_d;

  // Next-state and next-output logic; every output is registered from these.
  always_comb begin
    state_d   = state_q;
    a_d       = a_q;
    b_d       = b_q;
    fun_d     = fun_q;
    hi_d      = hi_q;
    cnt_d     = cnt_q;
    en_d      = 1'b0;
    tx_vld_d  = tx_vld_q;
    tx_data_d = tx_data_q;

    case (state_q)
      IDLE: begin
        if (RX_D_VLD) begin
          if (RX_P_DATA == CMD_ALU_OP)       state_d = GET_A;
          else if (RX_P_DATA == CMD_ALU_NOP) state_d = GET_FUN;
        end
      end
      GET_A: begin
        if (RX_D_VLD) begin
          a_d     = DATA_WIDTH'(RX_P_DATA);
          state_d = GET_B;
        end
      end
      GET_B: begin
        if (RX_D_VLD) begin
          b_d     = DATA_WIDTH'(RX_P_DATA);
          state_d = GET_FUN;
        end
      end
      GET_FUN: begin
        if (RX_D_VLD) begin
          if (is_valid_fun(RX_P_DATA, NUM_OPS)) begin
            fun_d   = opcode_t'(RX_P_DATA);
            en_d    = 1'b1;
            state_d = REQ;
          end else begin
            tx_vld_d  = 1'b1;
            tx_data_d = ERR_BAD_OP;
            state_d   = SEND_ERR;
          end
        end
      end
      REQ: begin
        cnt_d   = '0;
        state_d = WAIT;
      end
      // A valid result on the final counted cycle still beats the timeout.
      WAIT: begin
        if (ALU_OUT_VALID) begin
          hi_d      = ALU_OUT[2*DATA_WIDTH-1:DATA_WIDTH];
          tx_data_d = 8'(ALU_OUT[DATA_WIDTH-1:0]);
          tx_vld_d  = 1'b1;
          state_d   = SEND_LO;
        end else if (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
          tx_data_d = ERR_TIMEOUT;
          tx_vld_d  = 1'b1;
          state_d   = SEND_ERR;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      SEND_LO: begin
        if (!TX_BUSY) begin
          tx_data_d = 8'(hi_q);
          state_d   = SEND_HI;
        end
      end
      SEND_HI, SEND_ERR: begin
        if (!TX_BUSY) begin
          tx_vld_d = 1'b0;
          state_d  = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    busy_d = (state_d inside {REQ, WAIT, SEND_LO, SEND_HI, SEND_ERR});
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q   <= IDLE;
      a_q       <= '0;
      b_q       <= '0;
      fun_q     <= '0;
      hi_q      <= '0;
      cnt_q     <= '0;
      en_q      <= 1'b0;
      tx_vld_q  <= 1'b0;
      tx_data_q <= '0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      a_q       <= a_d;
      b_q       <= b_d;
      fun_q     <= fun_d;
      hi_q      <= hi_d;
      cnt_q     <= cnt_d;
      en_q      <= en_d;
      tx_vld_q  <= tx_vld_d;
      tx_data_q <= tx_data_d;
      busy_q    <= busy_d;
    end
  end

  assign ALU_EN    = en_q;
  assign ALU_A     = a_q;
  assign ALU_B     = b_q;
  assign ALU_FUN   = fun_q;
  assign TX_P_DATA = tx_data_q;
  assign TX_D_VLD  = tx_vld_q;
  assign CTRL_BUSY = busy_q;

endmodule

// File: tb/tb_alu_cmd_ctrl.sv
// Randomized self-checking bench for alu_cmd_ctrl with a frame-level reference model.
module tb_alu_cmd_ctrl;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic [7:0]  RX_P_DATA = '0;
  logic        RX_D_VLD = 1'b0;
  logic        ALU_EN;
  logic [7:0]  ALU_A, ALU_B;
  logic [3:0]  ALU_FUN;
  logic [15:0] ALU_OUT = '0;
  logic        ALU_OUT_VALID = 1'b0;
  logic [7:0]  TX_P_DATA;
  logic        TX_D_VLD;
  logic        TX_BUSY = 1'b0;
  logic        CTRL_BUSY;

  alu_cmd_ctrl dut (
    .CLK(CLK), .RST(RST), .RX_P_DATA(RX_P_DATA), .RX_D_VLD(RX_D_VLD),
    .ALU_EN(ALU_EN), .ALU_A(ALU_A), .ALU_B(ALU_B), .ALU_FUN(ALU_FUN),
    .ALU_OUT(ALU_OUT), .ALU_OUT_VALID(ALU_OUT_VALID),
    .TX_P_DATA(TX_P_DATA), .TX_D_VLD(TX_D_VLD), .TX_BUSY(TX_BUSY), .CTRL_BUSY(CTRL_BUSY)
  );

  always #5 CLK = ~CLK;

  typedef struct packed {
    logic [7:0] a;
    logic [7:0] b;
    logic [3:0] f;
  } op_t;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int strobe_cyc = 0;
  int busy_mode = 0;
  bit alu_respond = 1'b1;
  logic [7:0] ref_a = '0;
  logic [7:0] ref_b = '0;

  logic [7:0] obs_tx[$];
  logic [7:0] exp_tx[$];
  op_t        obs_ops[$];
  op_t        exp_ops[$];
  int         en_cyc[$];
  int         tx_rise[$];
  int         stab_err = 0;
  int         pulse_err = 0;
  logic       prev_vld = 1'b0, prev_busy = 1'b0, prev_en = 1'b0;
  logic [7:0] prev_data = '0;

  always @(posedge CLK) cyc++;

  function automatic logic [15:0] alu_fn(input logic [7:0] a, input logic [7:0] b,
                                         input logic [3:0] f);
    case (f)
      4'd0:    return {8'h00, a} + {8'h00, b};
      4'd1:    return {8'h00, a} - {8'h00, b};
      4'd2:    return {8'h00, a} * {8'h00, b};
      4'd3:    return (b == 8'h00) ? 16'h0000 : {8'h00, a / b};
      4'd4:    return {8'h00, a & b};
      4'd5:    return {8'h00, a | b};
      4'd6:    return {8'h00, ~(a & b)};
      4'd7:    return {8'h00, ~(a | b)};
      4'd8:    return {8'h00, a ^ b};
      4'd9:    return {8'h00, ~(a ^ b)};
      4'd10:   return {15'h0, a == b};
      4'd11:   return {15'h0, a > b};
      4'd12:   return {15'h0, a < b};
      default: return {8'h00, a >> 1};
    endcase
  endfunction

  // Single-cycle ALU: result and OUT_VALID one cycle after Enable.
  always @(posedge CLK) begin
    ALU_OUT_VALID <= ALU_EN & alu_respond;
    if (ALU_EN) ALU_OUT <= alu_fn(ALU_A, ALU_B, ALU_FUN);
  end

  always @(posedge CLK) begin
    #1;
    case (busy_mode)
      1:       TX_BUSY = 1'($urandom_range(0, 1));
      2:       TX_BUSY = 1'b1;
      default: TX_BUSY = 1'b0;
    endcase
  end

  // Monitor: ALU requests, TX transfers and TX hold behaviour.
  always @(negedge CLK) begin
    if (!RST) begin
      if (ALU_EN) begin
        obs_ops.push_back('{a: ALU_A, b: ALU_B, f: ALU_FUN});
        en_cyc.push_back(cyc);
      end
      if (ALU_EN && prev_en) pulse_err++;
      if (TX_D_VLD && !prev_vld) tx_rise.push_back(cyc);
      if (prev_vld && prev_busy && (!TX_D_VLD || TX_P_DATA !== prev_data)) stab_err++;
      if (TX_D_VLD && !TX_BUSY) obs_tx.push_back(TX_P_DATA);
    end
    prev_vld  = TX_D_VLD & !RST;
    prev_busy = TX_BUSY;
    prev_en   = ALU_EN & !RST;
    prev_data = TX_P_DATA;
  end

  function automatic string fmt_tx(input logic [7:0] q[$]);
    string s = "";
    foreach (q[i]) s = {s, $sformatf("%02h ", q[i])};
    return s;
  endfunction

  function automatic string fmt_ops(input op_t q[$]);
    string s = "";
    foreach (q[i]) s = {s, $sformatf("%02h/%02h/%0h ", q[i].a, q[i].b, q[i].f)};
    return s;
  endfunction

  task automatic clear_obs();
    obs_tx.delete(); obs_ops.delete(); en_cyc.delete(); tx_rise.delete();
    exp_tx.delete(); exp_ops.delete();
  endtask

  task automatic apply_reset(input int n);
    RST = 1'b1;
    RX_D_VLD = 1'b0;
    repeat (n) @(negedge CLK);
    RST = 1'b0;
    ref_a = '0;
    ref_b = '0;
  endtask

  task automatic send_byte(input logic [7:0] b);
    RX_P_DATA  = b;
    RX_D_VLD   = 1'b1;
    strobe_cyc = cyc;
    @(negedge CLK);
    RX_D_VLD = 1'b0;
  endtask

  // Frame-level reference: what the ALU should be asked and what comes back on TX.
  task automatic model_frame(input logic [7:0] fr[$]);
    logic [7:0]  fb;
    logic [15:0] r;
    if (fr[0] == 8'hCC) begin
      ref_a = fr[1];
      ref_b = fr[2];
      fb    = fr[3];
    end else begin
      fb = fr[1];
    end
    if (fb >= 8'd14) begin
      exp_tx.push_back(8'hEE);
    end else begin
      exp_ops.push_back('{a: ref_a, b: ref_b, f: fb[3:0]});
      if (!alu_respond) begin
        exp_tx.push_back(8'hFF);
      end else begin
        r = alu_fn(ref_a, ref_b, fb[3:0]);
        exp_tx.push_back(r[7:0]);
        exp_tx.push_back(r[15:8]);
      end
    end
  endtask

  task automatic wait_done(input int n_tx, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 300; i++) begin
      if (obs_tx.size() >= n_tx && !CTRL_BUSY && !TX_D_VLD) begin
        ok = 1'b1;
        return;
      end
      @(negedge CLK);
    end
  endtask

  task automatic do_frame(input logic [7:0] fr[$], input int max_gap, output bit ok);
    clear_obs();
    model_frame(fr);
    foreach (fr[i]) begin
      send_byte(fr[i]);
      repeat ($urandom_range(0, max_gap)) @(negedge CLK);
    end
    wait_done(exp_tx.size(), ok);
    repeat (2) @(negedge CLK);
  endtask

  task automatic test_reset();
    apply_reset(3);
    checks++;
    if ({ALU_EN, ALU_A, ALU_B, ALU_FUN, TX_P_DATA, TX_D_VLD, CTRL_BUSY} !== 31'h0) begin
      errors++;
      $display("FAIL reset_outputs: got en=%b a=%h b=%h fun=%h tx=%h vld=%b busy=%b, want all 0",
               ALU_EN, ALU_A, ALU_B, ALU_FUN, TX_P_DATA, TX_D_VLD, CTRL_BUSY);
    end
  endtask

  task automatic test_add();
    logic [7:0] fr[$];
    bit ok;
    int en_c, rise_c;
    fr = {8'hCC, 8'h0F, 8'h03, 8'h00};
    do_frame(fr, 0, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL add_done: reply not completed within bound"); end
    checks++;
    if (fmt_tx(obs_tx) != "12 00 ") begin
      errors++; $display("FAIL add_tx: got '%s' want '12 00 '", fmt_tx(obs_tx));
    end
    checks++;
    if (fmt_ops(obs_ops) != fmt_ops(exp_ops)) begin
      errors++; $display("FAIL add_ops: got '%s' want '%s'", fmt_ops(obs_ops), fmt_ops(exp_ops));
    end
    en_c   = (en_cyc.size() > 0) ? en_cyc[0] : -100;
    rise_c = (tx_rise.size() > 0) ? tx_rise[0] : -100;
    checks++;
    if (en_c - strobe_cyc != 1) begin
      errors++; $display("FAIL add_en_latency: got %0d want 1", en_c - strobe_cyc);
    end
    checks++;
    if (rise_c - en_c != 2) begin
      errors++; $display("FAIL add_tx_latency: got %0d want 2", rise_c - en_c);
    end
    checks++;
    if (pulse_err != 0) begin
      errors++; $display("FAIL alu_en_pulse: %0d multi-cycle pulses, want 0", pulse_err);
    end
  endtask

  task automatic test_nop();
    logic [7:0] fr[$];
    bit ok;
    fr = {8'hCC, 8'h0F, 8'h03, 8'h00};
    do_frame(fr, 1, ok);
    fr = {8'hDD, 8'h00};
    do_frame(fr, 1, ok);
    checks++;
    if (!ok || fmt_tx(obs_tx) != "12 00 " || fmt_ops(obs_ops) != "0f/03/0 ") begin
      errors++;
      $display("FAIL nop_reuse: done=%0b tx='%s' ops='%s' want tx='12 00 ' ops='0f/03/0 '",
               ok, fmt_tx(obs_tx), fmt_ops(obs_ops));
    end
    apply_reset(1);
    fr = {8'hDD, 8'h00};
    do_frame(fr, 0, ok);
    checks++;
    if (!ok || fmt_tx(obs_tx) != "00 00 " || fmt_ops(obs_ops) != "00/00/0 ") begin
      errors++;
      $display("FAIL nop_after_reset: done=%0b tx='%s' ops='%s' want tx='00 00 ' ops='00/00/0 '",
               ok, fmt_tx(obs_tx), fmt_ops(obs_ops));
    end
  endtask

  task automatic test_bad_op();
    logic [7:0] fr[$];
    bit ok;
    logic [7:0] fbs[2];
    fbs[0] = 8'h0E;
    fbs[1] = 8'h1F;
    foreach (fbs[k]) begin
      fr = {8'hCC, 8'h07, 8'h07, fbs[k]};
      do_frame(fr, 0, ok);
      checks++;
      if (!ok || fmt_tx(obs_tx) != "ee " || obs_ops.size() != 0) begin
        errors++;
        $display("FAIL bad_op_%02h: done=%0b tx='%s' alu_en=%0d want tx='ee ' alu_en=0",
                 fbs[k], ok, fmt_tx(obs_tx), obs_ops.size());
      end
    end
  endtask

  task automatic test_timeout();
    logic [7:0] fr[$];
    bit ok;
    int en_c, rise_c;
    alu_respond = 1'b0;
    fr = {8'hCC, 8'h05, 8'h06, 8'h02};
    do_frame(fr, 0, ok);
    alu_respond = 1'b1;
    checks++;
    if (!ok || fmt_tx(obs_tx) != "ff ") begin
      errors++; $display("FAIL timeout_tx: done=%0b tx='%s' want 'ff '", ok, fmt_tx(obs_tx));
    end
    en_c   = (en_cyc.size() > 0) ? en_cyc[0] : -100;
    rise_c = (tx_rise.size() > 0) ? tx_rise[0] : -100;
    checks++;
    if (rise_c - en_c != 17) begin
      errors++; $display("FAIL timeout_latency: got %0d want 17 (16 wait cycles)", rise_c - en_c);
    end
    fr = {8'hCC, 8'h05, 8'h06, 8'h02};
    do_frame(fr, 0, ok);
    checks++;
    if (!ok || fmt_tx(obs_tx) != "1e 00 ") begin
      errors++; $display("FAIL timeout_recover: done=%0b tx='%s' want '1e 00 '", ok, fmt_tx(obs_tx));
    end
  endtask

  task automatic test_tx_busy();
    logic [7:0] fr[$];
    bit ok;
    bit seen;
    clear_obs();
    stab_err  = 0;
    busy_mode = 2;
    fr = {8'hCC, 8'h0F, 8'h03, 8'h00};
    model_frame(fr);
    foreach (fr[i]) send_byte(fr[i]);
    seen = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      if (TX_D_VLD) seen = 1'b1;
      else @(negedge CLK);
    end
    send_byte(8'hCC);
    repeat (4) @(negedge CLK);
    checks++;
    if (!seen || TX_D_VLD !== 1'b1 || TX_P_DATA !== 8'h12 || obs_tx.size() != 0) begin
      errors++;
      $display("FAIL busy_hold: vld=%b data=%h transfers=%0d want vld=1 data=12 transfers=0",
               TX_D_VLD, TX_P_DATA, obs_tx.size());
    end
    busy_mode = 0;
    wait_done(2, ok);
    checks++;
    if (!ok || fmt_tx(obs_tx) != "12 00 " || stab_err != 0) begin
      errors++;
      $display("FAIL busy_release: done=%0b tx='%s' unstable=%0d want '12 00 ' unstable=0",
               ok, fmt_tx(obs_tx), stab_err);
    end
    repeat (2) @(negedge CLK);
    fr = {8'hCC, 8'h01, 8'h02, 8'h00};
    do_frame(fr, 0, ok);
    checks++;
    if (!ok || fmt_tx(obs_tx) != "03 00 " || fmt_ops(obs_ops) != "01/02/0 ") begin
      errors++;
      $display("FAIL busy_rx_dropped: done=%0b tx='%s' ops='%s' want '03 00 ' '01/02/0 '",
               ok, fmt_tx(obs_tx), fmt_ops(obs_ops));
    end
  endtask

  task automatic test_reset_abort();
    logic [7:0] fr[$];
    bit ok;
    clear_obs();
    send_byte(8'hCC);
    send_byte(8'h0F);
    apply_reset(1);
    @(negedge CLK);
    checks++;
    if ({ALU_EN, ALU_A, ALU_B, ALU_FUN, TX_P_DATA, TX_D_VLD, CTRL_BUSY} !== 31'h0) begin
      errors++;
      $display("FAIL reset_midframe: got a=%h b=%h fun=%h tx=%h vld=%b busy=%b, want all 0",
               ALU_A, ALU_B, ALU_FUN, TX_P_DATA, TX_D_VLD, CTRL_BUSY);
    end
    fr = {8'hCC, 8'h14, 8'h05, 8'h00};
    do_frame(fr, 0, ok);
    checks++;
    if (!ok || fmt_tx(obs_tx) != "19 00 ") begin
      errors++; $display("FAIL reset_then_frame: done=%0b tx='%s' want '19 00 '", ok, fmt_tx(obs_tx));
    end
    busy_mode = 2;
    clear_obs();
    fr = {8'hCC, 8'h01, 8'h01, 8'h00};
    foreach (fr[i]) send_byte(fr[i]);
    repeat (4) @(negedge CLK);
    apply_reset(1);
    busy_mode = 0;
    repeat (10) @(negedge CLK);
    checks++;
    if (obs_tx.size() != 0 || TX_D_VLD !== 1'b0 || CTRL_BUSY !== 1'b0) begin
      errors++;
      $display("FAIL reset_midsend: transfers=%0d vld=%b busy=%b want 0 0 0",
               obs_tx.size(), TX_D_VLD, CTRL_BUSY);
    end
  endtask

  task automatic test_random();
    bit ok;
    busy_mode = 1;
    for (int n = 0; n < 30; n++) begin
      logic [7:0] fr[$];
      logic [7:0] fb, junk;
      if ($urandom_range(0, 3) == 0) begin
        junk = 8'($urandom_range(0, 255));
        if (junk == 8'hCC || junk == 8'hDD) junk = 8'h00;
        send_byte(junk);
      end
      fb = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(14, 255)) : 8'($urandom_range(0, 13));
      if ($urandom_range(0, 2) == 0) fr = {8'hDD, fb};
      else fr = {8'hCC, 8'($urandom), 8'($urandom), fb};
      do_frame(fr, 2, ok);
      checks++;
      if (!ok || fmt_tx(obs_tx) != fmt_tx(exp_tx)) begin
        errors++;
        $display("FAIL rand_tx[%0d]: done=%0b got '%s' want '%s'", n, ok, fmt_tx(obs_tx), fmt_tx(exp_tx));
      end
      checks++;
      if (fmt_ops(obs_ops) != fmt_ops(exp_ops)) begin
        errors++;
        $display("FAIL rand_ops[%0d]: got '%s' want '%s'", n, fmt_ops(obs_ops), fmt_ops(exp_ops));
      end
    end
    busy_mode = 0;
    repeat (2) @(negedge CLK);
    checks++;
    if (stab_err != 0) begin
      errors++; $display("FAIL rand_tx_hold: %0d unstable held bytes, want 0", stab_err);
    end
  endtask

  initial begin
    @(negedge CLK);
    test_reset();
    test_add();
    test_nop();
    test_bad_op();
    test_timeout();
    test_tx_busy();
    test_reset_abort();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
